// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared default parameters for the pipe_reg slice chain
package pipe_reg_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_STAGES = 1;
endpackage

// File: rtl/pipe_reg_skid_stage.sv
// skid_stage: one 2-entry register slice (main + skid) with a registered upstream ready
module skid_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  logic main_v, skid_v, free, take;
  logic [WIDTH-1:0] main_d, skid_d;
  assign free = !main_v || m_ready;
  assign take = s_valid && !skid_v;
  assign s_ready = !skid_v;
  assign m_valid = main_v;
  assign m_data = main_d;
  // skid only fills while main is stuck, so take and skid_v are never both set
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (clr) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (free) begin
      main_v <= skid_v || take;
      if (skid_v || take) main_d <= skid_v ? skid_d : s_data;
      skid_v <= 1'b0;
    end else if (take) begin
      skid_v <= 1'b1;
      skid_d <= s_data;
    end
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: back-pressurable chain of STAGES skid slices with flush and occupancy count
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = $clog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [STAGES:0] v, r;
  logic [WIDTH-1:0] d [STAGES+1];
  logic in_xfer, out_xfer;
  if (STAGES < 1) begin : g_bad
    $error("pipe_reg: STAGES must be at least 1");
  end
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign r[STAGES] = out_ready;
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    skid_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk, .reset, .clr,
      .s_valid(v[i]), .s_ready(r[i]), .s_data(d[i]),
      .m_valid(v[i+1]), .m_ready(r[i+1]), .m_data(d[i+1])
    );
  end
  assign in_ready = r[0] && !clr && !reset;
  assign out_valid = v[STAGES] && !clr;
  assign out_data = d[STAGES];
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else count <= count + CW'(in_xfer) - CW'(out_xfer);
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: scoreboard bench driving STAGES=1,2,3 chains from one stimulus stream
module tb_pipe_reg;
  logic clk = 0, reset = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic ir [3];
  logic ov [3];
  logic [7:0] od [3];
  int cnt [3];
  int n_tests = 0, n_fail = 0;
  logic [7:0] sb [3][$];
  logic [7:0] got [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int S = g + 1;
    localparam int CW = $clog2(2 * S + 1);
    logic [CW-1:0] c;
    pipe_reg #(.WIDTH(8), .STAGES(S), .RESET_VAL(8'h5A)) dut (
      .clk, .reset, .clr, .in_valid, .in_ready(ir[g]), .in_data,
      .out_valid(ov[g]), .out_ready, .out_data(od[g]), .count(c)
    );
    assign cnt[g] = int'(c);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // inputs settle just after posedge, so the negedge view predicts the next edge's transfers
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) sb[k].delete();
      else begin
        chk($sformatf("s%0d_count_vs_sb", k + 1), cnt[k], sb[k].size());
        chk($sformatf("s%0d_count_max", k + 1), int'(cnt[k] <= 2 * (k + 1)), 1);
        if (ov[k]) begin
          if (sb[k].size() == 0) chk($sformatf("s%0d_spurious_valid", k + 1), 1, 0);
          else begin
            chk($sformatf("s%0d_out_data", k + 1), od[k], sb[k][0]);
            if (out_ready) begin
              if (k == 1) got.push_back(od[k]);
              void'(sb[k].pop_front());
            end
          end
        end
        if (clr) sb[k].delete();
        else if (in_valid && ir[k]) sb[k].push_back(in_data);
      end
    end
  end

  initial begin
    int idx, lat;
    logic acc;
    #2 reset = 1;
    #1;
    chk("rst_out_valid", ov[1], 0);
    chk("rst_count", cnt[1], 0);
    chk("rst_out_data", od[1], 8'h5A);
    chk("rst_in_ready", ir[1], 0);
    repeat (2) tick();
    reset = 0;
    #1 chk("in_ready_after_release", ir[1], 1);

    got.delete();
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1;
      in_data = 8'(i);
      tick();
      if (i == 1) chk("latency_not_yet", ov[1], 0);
      if (i == 2) begin
        chk("latency_valid", ov[1], 1);
        chk("latency_data", od[1], 1);
      end
      if (i >= 2) chk("stream_count", cnt[1], 2);
    end
    in_valid = 0;
    repeat (8) tick();
    chk("stream_n", got.size(), 16);
    foreach (got[j]) chk("stream_order", got[j], j + 1);

    got.delete();
    out_ready = 0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1;
      in_data = 8'hA0 + 8'(idx);
      acc = ir[1];
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_count", cnt[1], 4);
    chk("bp_in_ready", ir[1], 0);
    out_ready = 1;
    lat = 0;
    while (!ir[1] && lat < 10) begin
      tick();
      lat++;
    end
    chk("bp_ready_return", int'(lat <= 2), 1);
    for (int c = 0; c < 40 && idx < 8; c++) begin
      in_data = 8'hA0 + 8'(idx);
      acc = ir[1];
      tick();
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 8);
    in_valid = 0;
    repeat (8) tick();
    chk("bp_n", got.size(), 8);
    foreach (got[j]) chk("bp_order", got[j], 8'hA0 + j);

    got.delete();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = 8'h31 + 8'(i);
      tick();
    end
    chk("flush_fill_count", cnt[1], 3);
    clr = 1;
    in_data = 8'h55;
    out_ready = 1;
    #1;
    chk("clr_in_ready", ir[1], 0);
    chk("clr_out_valid", ov[1], 0);
    tick();
    clr = 0;
    in_valid = 0;
    chk("flush_count", cnt[1], 0);
    chk("flush_out_valid", ov[1], 0);
    repeat (6) tick();
    chk("flush_none_delivered", got.size(), 0);

    out_ready = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1;
      in_data = 8'h41 + 8'(idx);
      acc = ir[1];
      tick();
      if (acc) idx++;
    end
    in_valid = 0;
    chk("pre_reset_count", cnt[1], 4);
    #2 reset = 1;
    #1;
    chk("async_out_valid", ov[1], 0);
    chk("async_count", cnt[1], 0);
    chk("async_out_data", od[1], 8'h5A);
    repeat (2) tick();
    reset = 0;
    got.delete();
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      in_data = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 0;
    repeat (6) tick();
    chk("post_reset_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_reset_0", got[0], 8'h10);
      chk("post_reset_1", got[1], 8'h11);
    end

    for (int c = 0; c < 2000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (10) tick();
    for (int k = 0; k < 3; k++) chk($sformatf("s%0d_final_empty", k + 1), cnt[k], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
